// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the combinational ALU and the multi-word sequencer
// that drives it.
//   - OPC_* : ALU opcode encoding (0 is unused). Values 8 and 9 are the
//             ALU's rotates, which the sequencer does not chain.
//   - seq_state_t : sequencer state encoding.
//   - helper functions that classify opcodes for the sequencer.
// ----------------------------------------------------------------------------
package alu_pkg;

   localparam logic [3:0] OPC_ADD       = 4'd1;
   localparam logic [3:0] OPC_ADD_CARRY = 4'd2;
   localparam logic [3:0] OPC_SUB       = 4'd3;
   localparam logic [3:0] OPC_INC       = 4'd4;
   localparam logic [3:0] OPC_DEC       = 4'd5;
   localparam logic [3:0] OPC_AND       = 4'd6;
   localparam logic [3:0] OPC_NOT       = 4'd7;

   typedef enum logic [1:0] {
      IDLE,
      OP,
      FIX,
      DONE
   } seq_state_t;

   // Opcodes the sequencer can split into per-word ALU operations.
   function automatic logic opc_supported(input logic [3:0] opc);
      return opc inside {OPC_ADD, OPC_ADD_CARRY, OPC_SUB, OPC_INC,
                         OPC_DEC, OPC_AND, OPC_NOT};
   endfunction

   // Carry-chained opcodes; each word is issued to the ALU as ADD_CARRY.
   function automatic logic is_add_class(input logic [3:0] opc);
      return opc inside {OPC_ADD, OPC_ADD_CARRY, OPC_INC};
   endfunction

   // Borrow-chained opcodes; each word is issued as SUB, plus a DEC fix-up.
   function automatic logic is_sub_class(input logic [3:0] opc);
      return opc inside {OPC_SUB, OPC_DEC};
   endfunction

   // Starting value of the chain register: carry for the add class,
   // pending borrow for the subtract class.
   function automatic logic init_chain(input logic [3:0] opc, input logic cin);
      logic v;
      case (opc)
         OPC_ADD_CARRY: v = cin;
         OPC_INC:       v = 1'b1;
         OPC_DEC:       v = 1'b1;
         default:       v = 1'b0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/alu_chain_sequencer.sv
// ----------------------------------------------------------------------------
// alu_chain_sequencer
// Splits one WORDS x BUS_WIDTH command into per-word operations on an
// external combinational ALU, chaining carry/borrow between words, and
// presents the assembled wide result with aggregate flags.
//
// Ports
//   clk, reset        clock (rising edge), synchronous active-high reset
//   start             command strobe, only honoured in IDLE
//   opcode_in         ALU opcode for the whole command
//   a_in, b_in        wide operands, word 0 in the LSBs
//   carry_in          initial carry for ADD_CARRY
//   alu_opcode/a/b/carry_in   drive to the ALU (all zero in IDLE and DONE)
//   alu_y/carry_out/borrow/invalid_op   ALU response, captured same edge
//   busy              high in every state except IDLE
//   done              one-cycle pulse when result and flags are valid
//   result            assembled result, held until the next accepted start
//   carry_out, borrow_out, zero, invalid_op   aggregate flags, held likewise
// ----------------------------------------------------------------------------
module alu_chain_sequencer
   import alu_pkg::*;
#(
   parameter int BUS_WIDTH = 8,
   parameter int WORDS     = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [3:0]                 opcode_in,
   input  logic [WORDS*BUS_WIDTH-1:0] a_in,
   input  logic [WORDS*BUS_WIDTH-1:0] b_in,
   input  logic                       carry_in,
   output logic [3:0]                 alu_opcode,
   output logic [BUS_WIDTH-1:0]       alu_a,
   output logic [BUS_WIDTH-1:0]       alu_b,
   output logic                       alu_carry_in,
   input  logic [BUS_WIDTH-1:0]       alu_y,
   input  logic                       alu_carry_out,
   input  logic                       alu_borrow,
   input  logic                       alu_invalid_op,
   output logic                       busy,
   output logic                       done,
   output logic [WORDS*BUS_WIDTH-1:0] result,
   output logic                       carry_out,
   output logic                       borrow_out,
   output logic                       zero,
   output logic                       invalid_op
);

   localparam int TOTAL_W = WORDS * BUS_WIDTH;
   localparam int IDX_W   = $clog2(WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   seq_state_t           state_reg, state_next;
   logic [3:0]           op_reg;
   logic [IDX_W-1:0]     idx_reg;
   logic [TOTAL_W-1:0]   a_reg, b_reg;
   logic [BUS_WIDTH-1:0] work_reg [WORDS];
   logic                 chain_reg;       // carry (add class) or pending borrow (sub class)
   logic                 borrow_new_reg;  // SUB borrow held across the FIX cycle

   logic [TOTAL_W-1:0]   result_reg;
   logic                 carry_out_reg, borrow_out_reg, zero_reg, invalid_op_reg;

   logic [BUS_WIDTH-1:0] a_words [WORDS];
   logic [BUS_WIDTH-1:0] b_words [WORDS];
   logic [TOTAL_W-1:0]   final_flat;
   logic                 is_add, is_sub, is_last, need_fix, chain_next;

   // Word views of the operands, and the result as it stands once this
   // cycle's ALU output lands in the current word.
   genvar gi;
   generate
      for (gi = 0; gi < WORDS; gi++) begin : g_words
         assign a_words[gi] = a_reg[gi*BUS_WIDTH +: BUS_WIDTH];
         assign b_words[gi] = b_reg[gi*BUS_WIDTH +: BUS_WIDTH];
         assign final_flat[gi*BUS_WIDTH +: BUS_WIDTH] =
            (idx_reg == IDX_W'(gi)) ? alu_y : work_reg[gi];
      end
   endgenerate

   assign is_add   = is_add_class(op_reg);
   assign is_sub   = is_sub_class(op_reg);
   assign is_last  = (idx_reg == LAST_IDX);
   // A borrow left over from the previous word is applied to this word by a
   // separate DEC cycle rather than a borrow-in, since the ALU has none.
   assign need_fix = is_sub && chain_reg;

   always_comb begin
      state_next   = state_reg;
      alu_opcode   = '0;
      alu_a        = '0;
      alu_b        = '0;
      alu_carry_in = 1'b0;
      chain_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = opc_supported(opcode_in) ? OP : DONE;
            end
         end
         OP: begin
            alu_a = a_words[idx_reg];
            if (is_add) begin
               alu_opcode   = OPC_ADD_CARRY;
               alu_b        = (op_reg == OPC_INC) ? '0 : b_words[idx_reg];
               alu_carry_in = chain_reg;
               chain_next   = alu_carry_out;
            end else if (is_sub) begin
               alu_opcode = OPC_SUB;
               alu_b      = (op_reg == OPC_DEC) ? '0 : b_words[idx_reg];
               chain_next = alu_borrow;
            end else begin
               alu_opcode = op_reg;
               alu_b      = b_words[idx_reg];
            end

            if (alu_invalid_op) begin
               state_next = DONE;
            end else if (need_fix) begin
               state_next = FIX;
            end else if (is_last) begin
               state_next = DONE;
            end else begin
               state_next = OP;
            end
         end
         FIX: begin
            alu_opcode = OPC_DEC;
            alu_a      = work_reg[idx_reg];
            // SUB and DEC borrows on one word are mutually exclusive.
            chain_next = borrow_new_reg | alu_borrow;
            state_next = (alu_invalid_op || is_last) ? DONE : OP;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         op_reg         <= '0;
         idx_reg        <= '0;
         a_reg          <= '0;
         b_reg          <= '0;
         chain_reg      <= 1'b0;
         borrow_new_reg <= 1'b0;
         for (int i = 0; i < WORDS; i++) begin
            work_reg[i] <= '0;
         end
         result_reg     <= '0;
         carry_out_reg  <= 1'b0;
         borrow_out_reg <= 1'b0;
         zero_reg       <= 1'b0;
         invalid_op_reg <= 1'b0;
      end else begin
         state_reg <= state_next;

         if (state_reg == IDLE && start) begin
            if (opc_supported(opcode_in)) begin
               op_reg         <= opcode_in;
               a_reg          <= a_in;
               b_reg          <= b_in;
               idx_reg        <= '0;
               chain_reg      <= init_chain(opcode_in, carry_in);
               borrow_new_reg <= 1'b0;
            end else begin
               result_reg     <= '0;
               carry_out_reg  <= 1'b0;
               borrow_out_reg <= 1'b0;
               zero_reg       <= 1'b1;
               invalid_op_reg <= 1'b1;
            end
         end

         if (state_reg == OP || state_reg == FIX) begin
            if (alu_invalid_op) begin
               result_reg     <= '0;
               carry_out_reg  <= 1'b0;
               borrow_out_reg <= 1'b0;
               zero_reg       <= 1'b1;
               invalid_op_reg <= 1'b1;
            end else begin
               work_reg[idx_reg] <= alu_y;
               if (state_reg == OP && need_fix) begin
                  borrow_new_reg <= alu_borrow;
               end else begin
                  chain_reg <= chain_next;
                  if (is_last) begin
                     result_reg     <= final_flat;
                     carry_out_reg  <= is_add & chain_next;
                     borrow_out_reg <= is_sub & chain_next;
                     zero_reg       <= (final_flat == '0);
                     invalid_op_reg <= 1'b0;
                  end else begin
                     idx_reg <= idx_reg + 1'b1;
                  end
               end
            end
         end
      end
   end

   assign busy       = (state_reg != IDLE);
   assign done       = (state_reg == DONE);
   assign result     = result_reg;
   assign carry_out  = carry_out_reg;
   assign borrow_out = borrow_out_reg;
   assign zero       = zero_reg;
   assign invalid_op = invalid_op_reg;

endmodule
